// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared program/data memory: CPU on port 0, host loader on port 1.
// One access at a time through IDLE -> BUSY -> RESP; round-robin or CPU-priority on ties.
module mem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int MEM_LAT  = 1,
    parameter int PRIO_CPU = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] M_addr,
    output logic [DATA_W-1:0] M_data_out,
    output logic              Write_read,
    input  logic [DATA_W-1:0] M_data_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_q, wr_d;
    logic              pick;

    // Winner among the active requesters; only meaningful when at least one is asserted.
    function automatic logic pick_port(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return (PRIO_CPU != 0) ? 1'b0 : ~last;
        end
        return ~r0;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        wr_d     = wr_q;
        pick     = pick_port(req0, req1, last_q);

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BUSY;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    last_d  = pick;
                    cnt_d   = LAT_INIT;
                    addr_d  = pick ? addr1  : addr0;
                    wr_d    = pick ? we1    : we0;
                    dout_d  = pick ? wdata1 : wdata0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 3'd1;
                // Last access cycle: memory data is valid now, so capture and release the strobe.
                if (cnt_q <= 3'd1) begin
                    if (!wr_q) begin
                        if (gnt1_q) begin
                            rdata1_d = M_data_in;
                        end else begin
                            rdata0_d = M_data_in;
                        end
                    end
                    cnt_d   = 3'd0;
                    wr_d    = 1'b0;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            last_q   <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            wr_q     <= wr_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign M_addr     = addr_q;
    assign M_data_out = dout_q;
    assign Write_read = wr_q;

endmodule
